// File: rtl/bsg_manycore_mesh_req_arbiter_pkg.sv
// Shared types for the manycore mesh request arbiter.
//   arb_state_e        : run / drain / idle state of the port-quiescing FSM
//   packet_op_e        : manycore packet opcode (only loads are tracked)
//   load_id_idx_lsb_gp : bit position of the requester index inside load_id
package bsg_manycore_mesh_req_arbiter_pkg;

  typedef enum logic [1:0] {
    eRun   = 2'd0,
    eDrain = 2'd1,
    eIdle  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    e_remote_load  = 2'd0,
    e_remote_store = 2'd1,
    e_remote_amo   = 2'd2
  } packet_op_e;

  localparam int load_id_idx_lsb_gp = 0;

endpackage

// File: rtl/bsg_manycore_mesh_req_arbiter_rr_ptr.sv
// Round-robin pointer plus grant encoder.
// Picks the first set bit of v at or above the pointer (wrapping), purely
// combinationally. The pointer moves to grant_idx+1 only when yumi is high.
// Ports:
//   clk, reset   clock, async active-high reset (pointer -> 0)
//   v            per-requester eligibility
//   yumi         grant accepted this cycle
//   grant_v      any requester eligible
//   grant_idx    index of the selected requester
module bsg_manycore_mesh_req_arbiter_rr_ptr #(
  parameter int num_req_p = 4,
  localparam int lg_lp = $clog2(num_req_p)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [num_req_p-1:0] v,
  input  logic                 yumi,
  output logic                 grant_v,
  output logic [lg_lp-1:0]     grant_idx
);

  logic [lg_lp-1:0] ptr_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (yumi) begin
      ptr_r <= grant_idx + lg_lp'(1);
    end
  end

  // Walk from the farthest candidate back to the pointer so that the nearest
  // eligible requester is the last (winning) assignment. num_req_p is a power
  // of two, so the lg_lp-bit add wraps modulo num_req_p for free.
  always_comb begin
    logic [lg_lp-1:0] cand;
    cand      = '0;
    grant_v   = 1'b0;
    grant_idx = ptr_r;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      cand = ptr_r + lg_lp'(k);
      if (v[cand]) begin
        grant_v   = 1'b1;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/bsg_manycore_mesh_req_arbiter.sv
// Shares one manycore endpoint request port among num_req_p local requesters.
// Round-robin grant, per-requester outstanding-load counters, returned load
// data steered back by the requester index carried in load_id, and a drain
// FSM that stops granting until every outstanding load has come back.
// Ports:
//   clk_i, reset_i           clock, async active-high reset
//   req_v_i / req_packet_i   per-requester request valid and packet
//   req_yumi_o               one-hot accept back to the requesters
//   out_v_o / out_packet_o   request to the endpoint, load_id stamped
//   out_ready_i              endpoint can take a request
//   returned_*_i             load return from the endpoint
//   returned_yumi_o          return always consumed
//   resp_v_o / resp_data_o   one-hot return to requester, broadcast data
//   drain_i / drain_done_o   quiesce request, quiesced indication
//   loads_outstanding_o      per-requester outstanding load counts
//
// state  | meaning
// eRun   | granting normally
// eDrain | no grants, waiting for outstanding loads to return
// eIdle  | no grants, no loads outstanding, drain_done_o high
module bsg_manycore_mesh_req_arbiter
  import bsg_manycore_mesh_req_arbiter_pkg::*;
#(
  parameter int num_req_p       = 4,
  parameter int max_loads_p     = 8,
  parameter int x_cord_width_p  = 4,
  parameter int y_cord_width_p  = 4,
  parameter int data_width_p    = 32,
  parameter int addr_width_p    = 32,
  parameter int load_id_width_p = 11,
  localparam int lg_num_req_lp   = $clog2(num_req_p),
  localparam int cnt_width_lp    = $clog2(max_loads_p + 1),
  localparam int packet_width_lp = addr_width_p + 2 + data_width_p + load_id_width_p
                                   + 2 * (x_cord_width_p + y_cord_width_p)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_req_p-1:0]                 req_v_i,
  input  logic [num_req_p*packet_width_lp-1:0] req_packet_i,
  output logic [num_req_p-1:0]                 req_yumi_o,
  output logic                                 out_v_o,
  output logic [packet_width_lp-1:0]           out_packet_o,
  input  logic                                 out_ready_i,
  input  logic                                 returned_v_i,
  input  logic [data_width_p-1:0]              returned_data_i,
  input  logic [load_id_width_p-1:0]           returned_load_id_i,
  output logic                                 returned_yumi_o,
  output logic [num_req_p-1:0]                 resp_v_o,
  output logic [data_width_p-1:0]              resp_data_o,
  input  logic                                 drain_i,
  output logic                                 drain_done_o,
  output logic [num_req_p*cnt_width_lp-1:0]    loads_outstanding_o
);

  typedef struct packed {
    logic [addr_width_p-1:0]    addr;
    packet_op_e                 op;
    logic [data_width_p-1:0]    payload;
    logic [load_id_width_p-1:0] load_id;
    logic [y_cord_width_p-1:0]  src_y_cord;
    logic [x_cord_width_p-1:0]  src_x_cord;
    logic [y_cord_width_p-1:0]  y_cord;
    logic [x_cord_width_p-1:0]  x_cord;
  } packet_s;

  localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(max_loads_p);

  arb_state_e               state_r;
  logic                     drain_done_r;
  logic                     run, accept, grant_v, ret_v;
  logic [lg_num_req_lp-1:0] grant_idx, ret_idx;
  logic [num_req_p-1:0]     eligible, cnt_zero_n;
  packet_s                  pkts [num_req_p];
  packet_s                  stamped;

  // Reset gates every output combinationally so they drop the instant reset
  // asserts, without waiting for a clock edge.
  assign run             = ~reset_i & (state_r == eRun);
  assign out_v_o         = run & grant_v;
  assign accept          = out_v_o & out_ready_i;
  assign ret_v           = returned_v_i & ~reset_i;
  assign ret_idx         = returned_load_id_i[lg_num_req_lp-1:0];
  assign returned_yumi_o = ret_v;
  assign resp_data_o     = ret_v ? returned_data_i : '0;
  assign drain_done_o    = drain_done_r;

  bsg_manycore_mesh_req_arbiter_rr_ptr #(
    .num_req_p(num_req_p)
  ) u_rr (
    .clk       (clk_i),
    .reset     (reset_i),
    .v         (eligible),
    .yumi      (accept),
    .grant_v   (grant_v),
    .grant_idx (grant_idx)
  );

  always_comb begin
    req_yumi_o = '0;
    resp_v_o   = '0;
    req_yumi_o[grant_idx] = accept;
    resp_v_o[ret_idx]     = ret_v;
  end

  // The issuer index rides in the low load_id bits so the return can be
  // steered without any lookup table.
  always_comb begin
    stamped         = pkts[grant_idx];
    stamped.load_id = '0;
    stamped.load_id[load_id_idx_lsb_gp +: lg_num_req_lp] = grant_idx;
  end

  assign out_packet_o = out_v_o ? stamped : '0;

  for (genvar i = 0; i < num_req_p; i++) begin : g_req
    logic [cnt_width_lp-1:0] cnt_r, cnt_n;
    logic                    is_load, inc, dec;

    assign pkts[i]     = packet_s'(req_packet_i[i*packet_width_lp +: packet_width_lp]);
    assign is_load     = (pkts[i].op == e_remote_load);
    assign eligible[i] = req_v_i[i] & ~(is_load & (cnt_r == cnt_max_lp));
    assign inc         = accept & (grant_idx == lg_num_req_lp'(i)) & is_load;
    // A return against an empty counter is dropped so the count never wraps.
    assign dec         = ret_v & (ret_idx == lg_num_req_lp'(i)) & (cnt_r != '0);
    assign cnt_n       = cnt_r + cnt_width_lp'(inc) - cnt_width_lp'(dec);
    assign cnt_zero_n[i] = (cnt_n == '0);
    assign loads_outstanding_o[i*cnt_width_lp +: cnt_width_lp] = cnt_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_n;
      end
    end

    return_has_outstanding_load: assert property (
      @(posedge clk_i) disable iff (reset_i)
      !(returned_v_i && (ret_idx == lg_num_req_lp'(i)) && (cnt_r == '0)));
  end

  if (load_id_width_p > lg_num_req_lp) begin : g_id_hi
    logic unused_id_hi;
    assign unused_id_hi = ^returned_load_id_i[load_id_width_p-1:lg_num_req_lp];
  end

  // Drain looks at next-cycle counter values so a return that brings the last
  // counter to zero moves to eIdle on the same edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= eRun;
      drain_done_r <= 1'b0;
    end else begin
      case (state_r)
        eRun: begin
          if (drain_i) state_r <= eDrain;
        end
        eDrain: begin
          if (!drain_i) begin
            state_r <= eRun;
          end else if (&cnt_zero_n) begin
            state_r      <= eIdle;
            drain_done_r <= 1'b1;
          end
        end
        eIdle: begin
          if (!drain_i) begin
            state_r      <= eRun;
            drain_done_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= eRun;
          drain_done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_manycore_mesh_req_arbiter.sv
module tb_bsg_manycore_mesh_req_arbiter;
  import bsg_manycore_mesh_req_arbiter_pkg::*;

  localparam int N = 4;
  localparam int C = 4;
  localparam int D = 32;
  localparam int L = 11;
  localparam int P = 32 + 2 + 32 + 11 + 2 * (4 + 4);

  typedef struct packed {
    logic [31:0] addr;
    packet_op_e  op;
    logic [31:0] payload;
    logic [10:0] load_id;
    logic [3:0]  src_y_cord;
    logic [3:0]  src_x_cord;
    logic [3:0]  y_cord;
    logic [3:0]  x_cord;
  } packet_s;

  typedef struct {
    logic [N-1:0] yumi;
    packet_s      pkt;
  } grant_exp_t;

  typedef struct {
    logic [N-1:0] v;
    logic [D-1:0] data;
  } resp_exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_v;
  logic [N*P-1:0] req_packet;
  logic [N-1:0]   req_yumi;
  logic           out_v;
  logic [P-1:0]   out_packet;
  logic           out_ready;
  logic           returned_v;
  logic [D-1:0]   returned_data;
  logic [L-1:0]   returned_load_id;
  logic           returned_yumi;
  logic [N-1:0]   resp_v;
  logic [D-1:0]   resp_data;
  logic           drain;
  logic           drain_done;
  logic [N*C-1:0] loads_outstanding;

  packet_s    pkts [N];
  grant_exp_t gq [$];
  resp_exp_t  rq [$];
  grant_exp_t ge;
  resp_exp_t  re;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_packet = '0;
    for (int i = 0; i < N; i++) req_packet[i*P +: P] = pkts[i];
  end

  bsg_manycore_mesh_req_arbiter #(
    .num_req_p(4), .max_loads_p(8), .x_cord_width_p(4), .y_cord_width_p(4),
    .data_width_p(32), .addr_width_p(32), .load_id_width_p(11)
  ) dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .req_v_i             (req_v),
    .req_packet_i        (req_packet),
    .req_yumi_o          (req_yumi),
    .out_v_o             (out_v),
    .out_packet_o        (out_packet),
    .out_ready_i         (out_ready),
    .returned_v_i        (returned_v),
    .returned_data_i     (returned_data),
    .returned_load_id_i  (returned_load_id),
    .returned_yumi_o     (returned_yumi),
    .resp_v_o            (resp_v),
    .resp_data_o         (resp_data),
    .drain_i             (drain),
    .drain_done_o        (drain_done),
    .loads_outstanding_o (loads_outstanding)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic packet_s mk(input packet_op_e op, input logic [31:0] tag);
    packet_s p;
    p.addr       = tag ^ 32'h1000_0000;
    p.op         = op;
    p.payload    = tag;
    p.load_id    = 11'h7ff;
    p.src_y_cord = 4'h3;
    p.src_x_cord = 4'h5;
    p.y_cord     = 4'h9;
    p.x_cord     = 4'hc;
    return p;
  endfunction

  function automatic packet_s stamp(input packet_s p, input int idx);
    p.load_id      = '0;
    p.load_id[1:0] = idx[1:0];
    return p;
  endfunction

  function automatic logic [C-1:0] cnt_of(input int i);
    return loads_outstanding[i*C +: C];
  endfunction

  task automatic push_grant(input int idx);
    grant_exp_t g;
    g.yumi = 4'b0001 << idx;
    g.pkt  = stamp(pkts[idx], idx);
    gq.push_back(g);
  endtask

  task automatic send_return(input int idx, input logic [D-1:0] data);
    resp_exp_t r;
    returned_v       = 1'b1;
    returned_load_id = L'(idx);
    returned_data    = data;
    r.v    = 4'b0001 << idx;
    r.data = data;
    rq.push_back(r);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented grant or response must match the head of its queue.
  always @(negedge clk) begin
    if (req_yumi !== '0) begin
      if (gq.size() == 0) begin
        total++; bad++;
        $display("FAIL grant_unexpected: got yumi %b expected none at %0t", req_yumi, $time);
      end else begin
        ge = gq.pop_front();
        check("grant_yumi", 128'(req_yumi), 128'(ge.yumi));
        check("grant_packet", 128'(out_packet), 128'(ge.pkt));
      end
    end
    if (resp_v !== '0) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected: got resp_v %b expected none at %0t", resp_v, $time);
      end else begin
        re = rq.pop_front();
        check("resp_v", 128'(resp_v), 128'(re.v));
        check("resp_data", 128'(resp_data), 128'(re.data));
      end
    end
  end

  initial begin
    reset = 1'b1; req_v = '0; out_ready = 1'b0; returned_v = 1'b0;
    returned_data = '0; returned_load_id = '0; drain = 1'b0;
    for (int i = 0; i < N; i++) pkts[i] = mk(e_remote_store, 32'h100 + 32'(i));

    @(negedge clk);
    check("rst_out_v", 128'(out_v), 128'(0));
    check("rst_drain_done", 128'(drain_done), 128'(0));
    check("rst_counters", 128'(loads_outstanding), 128'(0));
    next_cycle();
    reset = 1'b0;

    // all stores: rotate 0,1,2,3,0
    out_ready = 1'b1;
    req_v     = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_grant(k % 4);
      next_cycle();
    end

    // stall: pointer and packet hold on requester 1
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_out_v", 128'(out_v), 128'(1));
      check("stall_yumi", 128'(req_yumi), 128'(0));
      check("stall_packet", 128'(out_packet), 128'(stamp(pkts[1], 1)));
      next_cycle();
    end
    req_v     = '0;
    out_ready = 1'b1;

    // requester 1 fills its load budget
    pkts[1] = mk(e_remote_load, 32'h200);
    req_v   = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      push_grant(1);
      next_cycle();
    end
    pkts[2] = mk(e_remote_store, 32'h300);
    req_v   = 4'b0110;
    push_grant(2);
    @(negedge clk);
    check("full_out_v", 128'(out_v), 128'(1));
    check("cnt1_full", 128'(cnt_of(1)), 128'(8));
    next_cycle();
    req_v = 4'b0010;
    send_return(1, 32'hcafe_0001);
    @(negedge clk);
    check("blocked_out_v", 128'(out_v), 128'(0));
    check("returned_yumi", 128'(returned_yumi), 128'(1));
    next_cycle();
    returned_v = 1'b0;
    push_grant(1);
    @(negedge clk);
    check("cnt1_after_ret", 128'(cnt_of(1)), 128'(7));
    next_cycle();
    req_v = '0;

    // simultaneous issue and return on requester 2
    pkts[2] = mk(e_remote_load, 32'h400);
    req_v   = 4'b0100;
    push_grant(2);
    next_cycle();
    push_grant(2);
    send_return(2, 32'hbeef_0002);
    @(negedge clk);
    check("same_cycle_resp_v", 128'(resp_v), 128'(4'b0100));
    next_cycle();
    returned_v = 1'b0;
    req_v      = '0;
    @(negedge clk);
    check("cnt2_inc_dec", 128'(cnt_of(2)), 128'(1));
    next_cycle();

    // set up counters 0,3,0,1 for requesters 0..3
    for (int k = 0; k < 5; k++) begin
      send_return(1, 32'hd000_0000 + 32'(k));
      next_cycle();
    end
    send_return(2, 32'hd000_0010);
    next_cycle();
    returned_v = 1'b0;
    pkts[3]    = mk(e_remote_load, 32'h500);
    req_v      = 4'b1000;
    push_grant(3);
    next_cycle();
    req_v = '0;
    @(negedge clk);
    check("cnt_pre_drain", 128'(loads_outstanding), 128'(16'h1030));
    next_cycle();

    // drain: grant in the sampling cycle completes, then nothing until drained
    drain = 1'b1;
    req_v = 4'b0001;
    push_grant(0);
    @(negedge clk);
    check("drain_done_early", 128'(drain_done), 128'(0));
    next_cycle();
    req_v = 4'b1111;
    @(negedge clk);
    check("drain_no_grant", 128'(out_v), 128'(0));
    next_cycle();
    send_return(1, 32'he000_0001); @(negedge clk); check("drain_wait_a", 128'(drain_done), 128'(0)); next_cycle();
    send_return(1, 32'he000_0002); @(negedge clk); check("drain_wait_b", 128'(drain_done), 128'(0)); next_cycle();
    send_return(1, 32'he000_0003); @(negedge clk); check("drain_wait_c", 128'(drain_done), 128'(0)); next_cycle();
    send_return(3, 32'he000_0004); @(negedge clk); check("drain_wait_d", 128'(drain_done), 128'(0)); next_cycle();
    returned_v = 1'b0;
    @(negedge clk);
    check("drain_done_rise", 128'(drain_done), 128'(1));
    check("idle_no_grant", 128'(out_v), 128'(0));
    next_cycle();
    drain = 1'b0;
    @(negedge clk);
    check("idle_hold", 128'(drain_done), 128'(1));
    check("idle_exit_no_grant", 128'(out_v), 128'(0));
    next_cycle();
    push_grant(1);
    @(negedge clk);
    check("drain_done_fall", 128'(drain_done), 128'(0));
    next_cycle();

    // async reset in the middle of a burst
    push_grant(2);
    next_cycle();
    #2;
    reset            = 1'b1;
    returned_v       = 1'b1;
    returned_load_id = L'(2);
    #1;
    check("areset_out_v", 128'(out_v), 128'(0));
    check("areset_yumi", 128'(req_yumi), 128'(0));
    check("areset_packet", 128'(out_packet), 128'(0));
    check("areset_counters", 128'(loads_outstanding), 128'(0));
    check("areset_ret_yumi", 128'(returned_yumi), 128'(0));
    check("areset_resp_v", 128'(resp_v), 128'(0));
    next_cycle();
    returned_v = 1'b0;
    reset      = 1'b0;
    push_grant(0);
    @(negedge clk);
    check("post_reset_counters", 128'(loads_outstanding), 128'(0));
    next_cycle();
    push_grant(1);
    next_cycle();
    req_v = '0;
    @(negedge clk);
    check("final_counters", 128'(loads_outstanding), 128'(16'h0010));
    next_cycle();
    next_cycle();
    check("grant_queue_empty", 128'(gq.size()), 128'(0));
    check("resp_queue_empty", 128'(rq.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
